// File: rtl/proc_test_pkg.sv
// Shared types and defaults for the processor run monitor.
// Table entries hold at most 64-bit PC and data values.
package proc_test_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_PC_W       = 64;
  localparam int DEF_WDOG_LIMIT = 255;
  localparam int DEF_RST_CYCLES = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_CHECK,
    S_NEXT,
    S_DONE
  } mon_state_t;

  typedef struct packed {
    logic                  en;
    logic [DEF_PC_W-1:0]   startpc;
    logic [DEF_PC_W-1:0]   endpc;
    logic [DEF_DATA_W-1:0] exp_val;
  } test_entry_t;

endpackage

// File: rtl/proc_run_monitor_wdog.sv
// Saturating run-cycle watchdog for the run monitor.
// expired is high while the count sits at LIMIT.
module watchdog_counter #(
  parameter int LIMIT = 255,
  parameter int W     = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == W'(LIMIT));

  // Count enabled cycles, holding at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/proc_run_monitor.sv
// Regression sequencer: resets, runs and checks the processor
// once per enabled table entry, tallying passes and failures.
module proc_run_monitor
  import proc_test_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int PC_W       = DEF_PC_W,
  parameter int NUM_TESTS  = 4,
  parameter int WDOG_LIMIT = DEF_WDOG_LIMIT,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int IDX_W      = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1,
  parameter int CNT_W      = $clog2(NUM_TESTS + 1)
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_en,
  input  logic [PC_W-1:0]      cfg_startpc,
  input  logic [PC_W-1:0]      cfg_endpc,
  input  logic [DATA_W-1:0]    cfg_expect,
  input  logic                 start,
  input  logic [PC_W-1:0]      currentpc,
  input  logic [DATA_W-1:0]    memtoreg,
  output logic                 proc_resetl,
  output logic [PC_W-1:0]      proc_startpc,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     cur_test,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     fail_count,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask,
  output logic                 all_passed
);

  localparam int HOLD_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  mon_state_t           state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [CNT_W-1:0]     pass_q, pass_d;
  logic [CNT_W-1:0]     fail_q, fail_d;
  logic [NUM_TESTS-1:0] fmask_q, fmask_d;
  logic [NUM_TESTS-1:0] tmask_q, tmask_d;
  logic [PC_W-1:0]      spc_q, spc_d;

  test_entry_t          tbl_q [NUM_TESTS];
  test_entry_t          wr_e;
  test_entry_t          cur_e;
  logic [NUM_TESTS-1:0] en_vec;
  logic                 cfg_ok;

  logic                 first_found, next_found;
  logic [IDX_W-1:0]     first_idx, next_idx;
  logic                 pc_reached, result_ok;
  logic                 wdog_clr, wdog_exp;

  assign cur_e      = tbl_q[cur_q];
  assign pc_reached = currentpc >= PC_W'(cur_e.endpc);
  assign result_ok  = memtoreg == DATA_W'(cur_e.exp_val);

  assign cfg_ok = cfg_we
                && (state_q == S_IDLE || state_q == S_DONE)
                && (int'(cfg_idx) < NUM_TESTS);

  assign wr_e.en      = cfg_en;
  assign wr_e.startpc = DEF_PC_W'(cfg_startpc);
  assign wr_e.endpc   = DEF_PC_W'(cfg_endpc);
  assign wr_e.exp_val = DEF_DATA_W'(cfg_expect);

  // Gather the per-entry enable bits for the index search.
  always_comb begin
    en_vec = '0;
    for (int i = 0; i < NUM_TESTS; i++) begin
      en_vec[i] = tbl_q[i].en;
    end
  end

  // Lowest enabled entry overall, and lowest above cur_q.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_TESTS - 1; i >= 0; i--) begin
      if (en_vec[i]) begin
        first_found = 1'b1;
        first_idx   = IDX_W'(i);
      end
      if (en_vec[i] && i > int'(cur_q)) begin
        next_found = 1'b1;
        next_idx   = IDX_W'(i);
      end
    end
  end

  // Watchdog runs only while the processor is in RUN.
  assign wdog_clr = (state_q != S_RUN);

  watchdog_counter #(
    .LIMIT (WDOG_LIMIT)
  ) u_wdog (
    .clk     (CLK),
    .rst     (reset),
    .clear   (wdog_clr),
    .en      (state_q == S_RUN),
    .expired (wdog_exp)
  );

  // Sequencer next-state and bookkeeping.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cur_d   = cur_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    fmask_d = fmask_q;
    tmask_d = tmask_q;
    spc_d   = spc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          pass_d  = '0;
          fail_d  = '0;
          fmask_d = '0;
          tmask_d = '0;
          hold_d  = '0;
          if (first_found) begin
            state_d = S_HOLD;
            cur_d   = first_idx;
            spc_d   = PC_W'(tbl_q[first_idx].startpc);
          end else begin
            state_d = S_DONE;
            cur_d   = '0;
          end
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (pc_reached) begin
          state_d = S_CHECK;
        end else if (wdog_exp) begin
          fmask_d[cur_q] = 1'b1;
          tmask_d[cur_q] = 1'b1;
          fail_d         = fail_q + CNT_W'(1);
          state_d        = S_NEXT;
        end
      end
      S_CHECK: begin
        if (result_ok) begin
          pass_d = pass_q + CNT_W'(1);
        end else begin
          fmask_d[cur_q] = 1'b1;
          fail_d         = fail_q + CNT_W'(1);
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (next_found) begin
          state_d = S_HOLD;
          cur_d   = next_idx;
          hold_d  = '0;
          spc_d   = PC_W'(tbl_q[next_idx].startpc);
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      cur_q   <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      fmask_q <= '0;
      tmask_q <= '0;
      spc_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cur_q   <= cur_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      fmask_q <= fmask_d;
      tmask_q <= tmask_d;
      spc_q   <= spc_d;
    end
  end

  // Test table; writes land only while no regression is active.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TESTS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      tbl_q[cfg_idx] <= wr_e;
    end
  end

  // Processor stays in reset except while its program runs.
  assign proc_resetl  = (state_q == S_RUN)
                      || (state_q == S_CHECK)
                      || (state_q == S_NEXT);
  assign busy         = (state_q == S_HOLD) || proc_resetl;
  assign done         = (state_q == S_DONE);
  assign proc_startpc = spc_q;
  assign cur_test     = cur_q;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;
  assign fail_mask    = fmask_q;
  assign timeout_mask = tmask_q;
  assign all_passed   = done && (fail_q == '0);

endmodule

// File: tb/tb_proc_run_monitor.sv
// Scoreboard bench for proc_run_monitor with a simple
// incrementing-PC processor model.
module tb_proc_run_monitor;
  import proc_test_pkg::*;

  localparam int NT = 4;
  localparam int DW = 64;
  localparam int PW = 64;
  localparam int IW = 2;
  localparam int CW = 3;
  localparam int RC = 2;

  logic          CLK = 1'b0;
  logic          reset;
  logic          cfg_we, cfg_en, start;
  logic [IW-1:0] cfg_idx;
  logic [PW-1:0] cfg_startpc, cfg_endpc;
  logic [DW-1:0] cfg_expect;
  logic [PW-1:0] currentpc;
  logic [DW-1:0] memtoreg;
  logic          proc_resetl, busy, done, all_passed;
  logic [PW-1:0] proc_startpc;
  logic [IW-1:0] cur_test;
  logic [CW-1:0] pass_count, fail_count;
  logic [NT-1:0] fail_mask, timeout_mask;

  always #5 CLK = ~CLK;

  proc_run_monitor #(
    .DATA_W(DW), .PC_W(PW), .NUM_TESTS(NT),
    .WDOG_LIMIT(255), .RST_CYCLES(RC)
  ) dut (
    .CLK(CLK), .reset(reset),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
    .cfg_startpc(cfg_startpc), .cfg_endpc(cfg_endpc),
    .cfg_expect(cfg_expect), .start(start),
    .currentpc(currentpc), .memtoreg(memtoreg),
    .proc_resetl(proc_resetl), .proc_startpc(proc_startpc),
    .busy(busy), .done(done), .cur_test(cur_test),
    .pass_count(pass_count), .fail_count(fail_count),
    .fail_mask(fail_mask), .timeout_mask(timeout_mask),
    .all_passed(all_passed)
  );

  // Processor model: PC loads in reset, then steps by 4.
  logic          stuck = 1'b0;
  logic [PW-1:0] pc = '0;
  logic [PW-1:0] m_end [NT] = '{default: '0};
  logic [DW-1:0] m_res [NT] = '{default: '0};

  always @(posedge CLK) begin
    if (!proc_resetl) pc <= proc_startpc;
    else if (stuck)   pc <= 64'h10;
    else              pc <= pc + 64'd4;
  end

  assign currentpc = pc;
  assign memtoreg  = (pc >= m_end[cur_test]) ? m_res[cur_test] : '0;

  typedef struct {
    int            idx;
    logic [PW-1:0] spc;
  } visit_t;

  typedef struct {
    int            pass;
    int            fail;
    logic [NT-1:0] fm;
    logic [NT-1:0] tm;
    logic          ap;
    int            cyc;
  } res_t;

  visit_t vq[$];
  res_t   rq[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: check each test launch and each regression end.
  int   lowcnt = 0;
  int   busycnt = 0;
  logic prl_prev = 1'b0;
  logic done_prev = 1'b0;

  always @(negedge CLK) begin
    if (reset) begin
      lowcnt = 0; busycnt = 0;
      prl_prev = 1'b0; done_prev = 1'b0;
    end else begin
      if (busy) busycnt++;
      if (busy && !proc_resetl) lowcnt++;
      if (busy && proc_resetl && !prl_prev) begin
        if (vq.size() == 0) begin
          checks++; errors++;
          $display("FAIL visit unexpected test=%0d", cur_test);
        end else begin
          visit_t v;
          v = vq.pop_front();
          chk("visit_idx", 64'(cur_test), 64'(v.idx));
          chk("visit_spc", proc_startpc, v.spc);
          chk("hold_cycles", 64'(lowcnt), 64'(RC));
        end
        lowcnt = 0;
      end
      if (done && !done_prev) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done unexpected");
        end else begin
          res_t r;
          r = rq.pop_front();
          chk("pass_count", 64'(pass_count), 64'(r.pass));
          chk("fail_count", 64'(fail_count), 64'(r.fail));
          chk("fail_mask", 64'(fail_mask), 64'(r.fm));
          chk("timeout_mask", 64'(timeout_mask), 64'(r.tm));
          chk("all_passed", 64'(all_passed), 64'(r.ap));
          chk("busy_cycles", 64'(busycnt), 64'(r.cyc));
        end
        busycnt = 0;
      end
      prl_prev  = proc_resetl;
      done_prev = done;
    end
  end

  task automatic wr(int i, logic en, logic [63:0] sp,
                    logic [63:0] ep, logic [63:0] ex,
                    logic [63:0] res);
    @(negedge CLK);
    cfg_we = 1'b1; cfg_idx = IW'(i); cfg_en = en;
    cfg_startpc = sp; cfg_endpc = ep; cfg_expect = ex;
    @(negedge CLK);
    cfg_we = 1'b0;
    m_end[i] = ep;
    m_res[i] = res;
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_done(int lim);
    for (int n = 0; n < lim && !done; n++) @(negedge CLK);
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done timeout done=%0b", done);
    end
  endtask

  task automatic push_v(int i, logic [63:0] sp);
    visit_t v;
    v.idx = i; v.spc = sp;
    vq.push_back(v);
  endtask

  task automatic push_r(int p, int f, logic [NT-1:0] fm,
                        logic [NT-1:0] tm, logic ap, int cyc);
    res_t r;
    r.pass = p; r.fail = f; r.fm = fm;
    r.tm = tm; r.ap = ap; r.cyc = cyc;
    rq.push_back(r);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_resetl"}, 64'(proc_resetl), 64'd0);
    chk({tag, "_startpc"}, proc_startpc, 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cur"}, 64'(cur_test), 64'd0);
    chk({tag, "_pass"}, 64'(pass_count), 64'd0);
    chk({tag, "_fail"}, 64'(fail_count), 64'd0);
    chk({tag, "_fmask"}, 64'(fail_mask), 64'd0);
    chk({tag, "_tmask"}, 64'(timeout_mask), 64'd0);
    chk({tag, "_allp"}, 64'(all_passed), 64'd0);
  endtask

  localparam logic [63:0] EXA = 64'h1234_5678_9abc_def0;

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_en = 1'b0; start = 1'b0;
    cfg_idx = '0; cfg_startpc = '0; cfg_endpc = '0;
    cfg_expect = '0;
    repeat (2) @(negedge CLK);
    chk_reset_vals("por");
    reset = 1'b0;

    // Single passing test: 22 RUN cycles.
    wr(0, 1'b1, 64'h0, 64'h54, EXA, EXA);
    push_v(0, 64'h0);
    push_r(1, 0, 4'b0000, 4'b0000, 1'b1, 26);
    pulse_start();
    wait_done(1000);

    // Stuck PC: timeout after 256 RUN cycles.
    stuck = 1'b1;
    push_v(0, 64'h0);
    push_r(0, 1, 4'b0001, 4'b0001, 1'b0, 259);
    pulse_start();
    wait_done(1000);
    stuck = 1'b0;

    // Entries 1 and 3 disabled, entry 2 gets a wrong result.
    wr(1, 1'b0, 64'h40, 64'h48, 64'h1, 64'h1);
    wr(2, 1'b1, 64'h100, 64'h110, 64'hAAAA, 64'hBBBB);
    wr(3, 1'b0, 64'h80, 64'h88, 64'h2, 64'h2);
    push_v(0, 64'h0);
    push_v(2, 64'h100);
    push_r(1, 1, 4'b0100, 4'b0000, 1'b0, 35);
    pulse_start();
    wait_done(1000);

    // End PC on the same edge the watchdog reaches its limit.
    wr(0, 1'b1, 64'h0, 64'h3FC, 64'h77, 64'h77);
    wr(2, 1'b0, 64'h0, 64'h0, 64'h0, 64'h0);
    push_v(0, 64'h0);
    push_r(1, 0, 4'b0000, 4'b0000, 1'b1, 260);
    pulse_start();
    wait_done(1000);

    // cfg_we and start while busy must be ignored.
    wr(0, 1'b1, 64'h0, 64'h54, EXA, EXA);
    push_v(0, 64'h0);
    push_r(1, 0, 4'b0000, 4'b0000, 1'b1, 26);
    pulse_start();
    repeat (5) @(negedge CLK);
    start = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd0;
    cfg_en = 1'b1; cfg_startpc = 64'h8;
    cfg_endpc = 64'h10; cfg_expect = 64'hDEAD;
    @(negedge CLK);
    start = 1'b0; cfg_idx = 2'd1;
    cfg_we = 1'b1;
    @(negedge CLK);
    cfg_we = 1'b0;
    wait_done(1000);
    push_v(0, 64'h0);
    push_r(1, 0, 4'b0000, 4'b0000, 1'b1, 26);
    pulse_start();
    wait_done(1000);

    // Reset mid-RUN of test 1, then start on an empty table.
    wr(1, 1'b1, 64'h200, 64'h210, 64'h55, 64'h55);
    push_v(0, 64'h0);
    push_v(1, 64'h200);
    pulse_start();
    for (int n = 0; n < 200 && !(cur_test == 2'd1 && proc_resetl);
         n++) @(negedge CLK);
    chk("reach_test1_run", 64'(cur_test == 2'd1 && proc_resetl),
        64'd1);
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    push_r(0, 0, 4'b0000, 4'b0000, 1'b1, 0);
    pulse_start();
    wait_done(20);
    @(negedge CLK);

    chk("visit_q_empty", 64'(vq.size()), 64'd0);
    chk("res_q_empty", 64'(rq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_run_monitor.md
# proc_run_monitor

Synthesizable, parametrised run controller and result checker for the single-cycle processor. It sequences up to NUM_TESTS programs: per test it holds the processor in reset, releases it at a programmed start PC, watches `currentpc` until a programmed end PC, and compares `MemtoRegOut` against an expected value. A per-test watchdog aborts runaway programs. It tallies passes and failures, so multi-program regressions run on hardware or in a bench without hand-written sequencing.

## Interface
- DATA_W, 64, width of the monitored result and expected values
- PC_W, 64, width of the PC values
- NUM_TESTS, 4, number of test-table entries (at least 1)
- WDOG_LIMIT, 255, maximum RUN cycles per test before timeout
- RST_CYCLES, 2, cycles `proc_resetl` is held low before each test
- IDX_W, $clog2(NUM_TESTS) (minimum 1), test-index width (derived)
- CNT_W, $clog2(NUM_TESTS+1), pass/fail counter width (derived)

Ports:
- CLK  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cfg_we  in  1  table write strobe
- cfg_idx  in  IDX_W  table entry to write
- cfg_en  in  1  entry enable; disabled entries are skipped
- cfg_startpc  in  PC_W  start PC for the entry
- cfg_endpc  in  PC_W  end PC for the entry
- cfg_expect  in  DATA_W  expected `MemtoRegOut` value
- start  in  1  one-cycle pulse that begins a regression
- currentpc  in  PC_W  processor PC
- memtoreg  in  DATA_W  processor `MemtoRegOut`
- proc_resetl  out  1  active-low reset to the processor
- proc_startpc  out  PC_W  start PC to the processor
- busy  out  1  regression in progress
- done  out  1  regression finished (sticky)
- cur_test  out  IDX_W  index of the active test
- pass_count  out  CNT_W  tests passed
- fail_count  out  CNT_W  tests failed, including timeouts
- fail_mask  out  NUM_TESTS  bit i set when test i fails
- timeout_mask  out  NUM_TESTS  bit i set when test i times out
- all_passed  out  1  asserted when `done` is high and `fail_count` is 0

## Operation
- States:
  - IDLE: wait for `start`.
  - HOLD: drive `proc_resetl` low for RST_CYCLES cycles.
  - RUN: processor executes.
  - CHECK: compare the result.
  - NEXT: advance to the next test.
  - DONE: regression complete.
- IDLE → HOLD on `start`:
  - clear the counters and masks;
  - set `cur_test` to the first enabled entry;
  - if no entry is enabled, go directly to DONE.
- HOLD: `proc_startpc` = `startpc[cur_test]`. After RST_CYCLES cycles go to RUN and drive `proc_resetl` high.
- RUN:
  - The watchdog counter increments every cycle.
  - If `currentpc` ≥ `endpc[cur_test]` (unsigned compare), go to CHECK.
  - Otherwise, if the watchdog equals WDOG_LIMIT, set `fail_mask[i]` and `timeout_mask[i]`, increment `fail_count`, and go to NEXT.
  - If both conditions hold on the same edge, end-PC detection wins.
- CHECK (one settle cycle for write-back): on this edge, if `memtoreg` == `expect[cur_test]`, increment `pass_count`; otherwise set `fail_mask[i]` and increment `fail_count`. Then go to NEXT.
- NEXT:
  - clear the watchdog;
  - advance `cur_test` to the next enabled index;
  - go to HOLD if one exists, otherwise to DONE.
- DONE: `done` = 1. A `start` pulse here restarts the regression exactly as from IDLE.
- `start` is ignored in HOLD, RUN, CHECK and NEXT.
- `cfg_we` is honoured only in IDLE or DONE. Writes with `cfg_idx` ≥ NUM_TESTS are ignored.
- Counters cannot overflow, because each is at most NUM_TESTS.

## Timing
- Reset values:
  - state = IDLE;
  - `proc_resetl` = 0 (processor held in reset while idle);
  - `proc_startpc` = 0;
  - `busy`, `done`, `all_passed`, `cur_test`, both counters, both masks = 0;
  - every table entry cleared with `en` = 0.
- Assertion of `reset` in any state returns immediately, asynchronously, to the reset values; the regression is discarded.
- `busy` = 1 in HOLD, RUN, CHECK and NEXT.
- Latency for one enabled test: `start` edge → HOLD (RST_CYCLES) → RUN (k cycles) → CHECK (1) → NEXT (1), for RST_CYCLES + k + 2 cycles before `done` or the next HOLD.
- A timeout occurs on the RUN edge where the watchdog equals WDOG_LIMIT, i.e. after WDOG_LIMIT+1 RUN cycles.
- A table write takes effect at the next edge; a write and `start` on the same edge uses the old entry contents.

## Structure
- Package `proc_test_pkg`:
  - the state enum `mon_state_t`;
  - default parameter constants (64, 255, 2);
  - the table-entry struct {en, startpc, endpc, expect}.
- Sub-module `watchdog_counter`: parametrised width and limit; ports `clear`, `en` and `expired`; same clock and reset.
- Top-level: FSM, test table, next-enabled-index priority search, and comparators.

## Test plan
- NUM_TESTS=1, entry0 {en=1, start=0, end=0x54, expect=0x123456789abcdef0}; the model PC increments by 4 and memtoreg = expect at PC 0x54. Expect `pass_count`=1, `done`=1, `all_passed`=1, and `proc_resetl` low for exactly 2 cycles.
- Same setup, but the model PC is stuck at 0x10. Expect a timeout after 256 RUN cycles, with `timeout_mask`=1, `fail_count`=1 and `all_passed`=0.
- NUM_TESTS=4 with entries 1 and 3 disabled, entry 0 passing and entry 2 with a wrong result. Expect `pass_count`=1, `fail_mask`=4'b0100, and `cur_test` visiting only 0 and 2.
- End PC reached on the same edge the watchdog hits the limit. Expect the test to go to CHECK and pass, with `timeout_mask`=0.
- `reset` pulsed mid-RUN in test 1. Expect all outputs at reset values within the same cycle and every entry disabled; a subsequent `start` goes directly to DONE.
- `cfg_we` and `start` pulsed while busy. Expect both ignored, with table contents and counters unchanged.
